fetch_stage: RTL and testbench

//  Instruction-fetch stage upstream of the control unit. Owns the PC, issues
//  req/ack fetches to instruction memory and holds the IF/ID register. The ID

---
 rtl/mips_pkg.sv | 28 ++
 rtl/npc_sel.sv | 30 +++
 rtl/fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch reset constants and the
// fetch-stage state encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HOLD    = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/npc_sel.sv
// Redirect target selection for the fetch stage: jr beats j/jal beats branch.
// Every target is forced onto a word boundary.
module npc_sel
    import mips_pkg::*;
(
    input  logic        i_jump,
    input  logic        i_jmp_reg,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jr_addr,
    input  logic [3:0]  i_pc4_hi,
    input  logic [25:0] i_jidx,
    output logic [31:0] o_target,
    output logic        o_jr_misalign
);

    logic [31:0] raw_target;

    always_comb begin
        raw_target    = i_branch_target;
        o_jr_misalign = 1'b0;
        if (i_jump && i_jmp_reg) begin
            raw_target    = i_jr_addr;
            o_jr_misalign = |i_jr_addr[1:0];
        end else if (i_jump) begin
            raw_target = {i_pc4_hi, i_jidx, 2'b00};
        end
        o_target = word_align(raw_target);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack instruction-memory port, skid buffer
// for stalls, redirect handling and the IF/ID pipeline register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic        i_jmp_reg,
    input  logic [31:0] i_jr_addr,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc4,
    output logic        o_id_valid,
    output logic [5:0]  o_instr_code,
    output logic        o_align_err
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  addr_reg, addr_next;
    logic         req_reg, req_next;
    logic [31:0]  id_instr_reg, id_instr_next;
    logic [31:0]  id_pc4_reg, id_pc4_next;
    logic         id_valid_reg, id_valid_next;
    logic [31:0]  skid_data_reg, skid_data_next;
    logic [31:0]  skid_pc_reg, skid_pc_next;
    logic         align_err_reg, align_err_next;

    logic [31:0]  target;
    logic         jr_misalign;
    logic         redirect;

    npc_sel u_npc_sel (
        .i_jump          (i_jump),
        .i_jmp_reg       (i_jmp_reg),
        .i_branch_target (i_branch_target),
        .i_jr_addr       (i_jr_addr),
        .i_pc4_hi        (id_pc4_reg[31:28]),
        .i_jidx          (id_instr_reg[25:0]),
        .o_target        (target),
        .o_jr_misalign   (jr_misalign)
    );

    // Redirects only come from a real instruction that ID is actually consuming.
    assign redirect = (i_jump | i_branch_taken) & id_valid_reg & ~i_stall;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        addr_next      = addr_reg;
        req_next       = req_reg;
        id_instr_next  = id_instr_reg;
        id_pc4_next    = id_pc4_reg;
        id_valid_next  = id_valid_reg;
        skid_data_next = skid_data_reg;
        skid_pc_next   = skid_pc_reg;
        align_err_next = align_err_reg | (redirect & jr_misalign);

        // Whenever ID consumes IF/ID without a fresh word arriving, a bubble
        // takes its place so nothing is executed twice.
        if (!i_stall && state_reg != ST_IDLE) begin
            id_instr_next = NOP_INSTR;
            id_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                req_next   = 1'b1;
                addr_next  = pc_reg;
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_imem_ack) begin
                    if (i_stall) begin
                        skid_data_next = i_imem_data;
                        skid_pc_next   = addr_reg;
                        req_next       = 1'b0;
                        state_next     = ST_HOLD;
                    end else if (redirect) begin
                        pc_next   = target;
                        addr_next = target;
                    end else begin
                        id_instr_next = i_imem_data;
                        id_pc4_next   = addr_reg + 32'd4;
                        id_valid_next = 1'b1;
                        pc_next       = addr_reg + 32'd4;
                        addr_next     = addr_reg + 32'd4;
                    end
                end else if (redirect) begin
                    // The in-flight access must still complete; its word is junk.
                    pc_next    = target;
                    state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    pc_next = target;
                end
                if (i_imem_ack) begin
                    addr_next  = redirect ? target : pc_reg;
                    state_next = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!i_stall) begin
                    req_next   = 1'b1;
                    state_next = ST_FETCH;
                    if (redirect) begin
                        pc_next   = target;
                        addr_next = target;
                    end else begin
                        id_instr_next = skid_data_reg;
                        id_pc4_next   = skid_pc_reg + 32'd4;
                        id_valid_next = 1'b1;
                        pc_next       = skid_pc_reg + 32'd4;
                        addr_next     = skid_pc_reg + 32'd4;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= RESET_PC;
            addr_reg      <= RESET_PC;
            req_reg       <= 1'b0;
            id_instr_reg  <= NOP_INSTR;
            id_pc4_reg    <= 32'd0;
            id_valid_reg  <= 1'b0;
            skid_data_reg <= 32'd0;
            skid_pc_reg   <= 32'd0;
            align_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            addr_reg      <= addr_next;
            req_reg       <= req_next;
            id_instr_reg  <= id_instr_next;
            id_pc4_reg    <= id_pc4_next;
            id_valid_reg  <= id_valid_next;
            skid_data_reg <= skid_data_next;
            skid_pc_reg   <= skid_pc_next;
            align_err_reg <= align_err_next;
        end
    end

    assign o_imem_req   = req_reg;
    assign o_imem_addr  = addr_reg;
    assign o_id_instr   = id_instr_reg;
    assign o_id_pc4     = id_pc4_reg;
    assign o_id_valid   = id_valid_reg;
    assign o_instr_code = id_instr_reg[31:26];
    assign o_align_err  = align_err_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory responder plus a
// transaction-level model of the fetch stream, IF/ID and the error flag.
module tb_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_data = 32'd0;
    logic        i_stall = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_target = 32'd0;
    logic        i_jump = 1'b0;
    logic        i_jmp_reg = 1'b0;
    logic [31:0] i_jr_addr = 32'd0;
    logic [31:0] o_id_instr;
    logic [31:0] o_id_pc4;
    logic        o_id_valid;
    logic [5:0]  o_instr_code;
    logic        o_align_err;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ack      (i_imem_ack),
        .i_imem_data     (i_imem_data),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jmp_reg       (i_jmp_reg),
        .i_jr_addr       (i_jr_addr),
        .o_id_instr      (o_id_instr),
        .o_id_pc4        (o_id_pc4),
        .o_id_valid      (o_id_valid),
        .o_instr_code    (o_instr_code),
        .o_align_err     (o_align_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: outstanding request, pending discard, held word, IF/ID
    logic        m_started, m_req, m_kill, m_held, m_idv, m_err;
    logic [31:0] m_addr, m_resume, m_hword, m_hpc, m_idi, m_idp4;

    // Memory responder
    logic        mem_busy;
    int          mem_left;
    int          mem_lat;
    logic [31:0] ovr_addr, ovr_word;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ovr_addr) return ovr_word;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_req = 1'b0; m_kill = 1'b0; m_held = 1'b0;
        m_idv = 1'b0; m_err = 1'b0;
        m_addr = RPC; m_resume = RPC; m_hword = 32'd0; m_hpc = 32'd0;
        m_idi = 32'd0; m_idp4 = 32'd0;
        mem_busy = 1'b0; mem_left = 0;
    endtask

    task automatic model_step();
        logic        got, redir, bad;
        logic [31:0] tgt, word;
        if (!m_started) begin
            m_started = 1'b1;
            m_req = 1'b1;
            m_addr = RPC;
            return;
        end
        got   = i_imem_ack & m_req;
        word  = mem_word(m_addr);
        redir = (i_jump | i_branch_taken) & m_idv & ~i_stall;
        bad   = 1'b0;
        if (i_jump && i_jmp_reg) begin
            tgt = {i_jr_addr[31:2], 2'b00};
            bad = (i_jr_addr[1:0] != 2'b00);
        end else if (i_jump) begin
            tgt = {m_idp4[31:28], m_idi[25:0], 2'b00};
        end else begin
            tgt = {i_branch_target[31:2], 2'b00};
        end

        if (i_stall) begin
            if (got && m_kill) begin
                m_kill = 1'b0; m_addr = m_resume;
            end else if (got) begin
                m_held = 1'b1; m_hword = word; m_hpc = m_addr; m_req = 1'b0;
            end
        end else if (redir) begin
            m_idv = 1'b0; m_idi = 32'd0;
            if (bad) m_err = 1'b1;
            if (!m_req) begin
                m_held = 1'b0; m_req = 1'b1; m_addr = tgt;
            end else if (got) begin
                m_kill = 1'b0; m_addr = tgt;
            end else begin
                m_kill = 1'b1; m_resume = tgt;
            end
        end else if (m_held) begin
            m_idv = 1'b1; m_idi = m_hword; m_idp4 = m_hpc + 32'd4;
            m_held = 1'b0; m_req = 1'b1; m_addr = m_hpc + 32'd4;
        end else if (got && !m_kill) begin
            m_idv = 1'b1; m_idi = word; m_idp4 = m_addr + 32'd4;
            m_addr = m_addr + 32'd4;
        end else begin
            m_idv = 1'b0; m_idi = 32'd0;
            if (got) begin
                m_kill = 1'b0; m_addr = m_resume;
            end
        end
    endtask

    task automatic tick();
        if (!mem_busy && o_imem_req) begin
            mem_busy = 1'b1;
            mem_left = mem_lat - 1;
        end
        i_imem_ack  = mem_busy && (mem_left == 0);
        i_imem_data = i_imem_ack ? mem_word(o_imem_addr) : $urandom();
        model_step();
        @(posedge clk);
        #1;
        if (i_imem_ack) mem_busy = 1'b0;
        else if (mem_busy) mem_left--;
        cyc++;
        $display("cyc=%0d ack=%b stall=%b req=%b addr=%h id_valid=%b id_pc4=%h id_instr=%h err=%b",
                 cyc, i_imem_ack, i_stall, o_imem_req, o_imem_addr, o_id_valid, o_id_pc4,
                 o_id_instr, o_align_err);
        check("req",        32'(o_imem_req),   32'(m_req));
        check("addr",       o_imem_addr,       m_addr);
        check("id_instr",   o_id_instr,        m_idi);
        check("id_pc4",     o_id_pc4,          m_idp4);
        check("id_valid",   32'(o_id_valid),   32'(m_idv));
        check("instr_code", 32'(o_instr_code), 32'(m_idi[31:26]));
        check("align_err",  32'(o_align_err),  32'(m_err));
    endtask

    task automatic clear_redirect();
        i_branch_taken = 1'b0; i_jump = 1'b0; i_jmp_reg = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(o_imem_req),  32'd0);
        check({tag, "_addr"},  o_imem_addr,      RPC);
        check({tag, "_instr"}, o_id_instr,       32'd0);
        check({tag, "_pc4"},   o_id_pc4,         32'd0);
        check({tag, "_valid"}, 32'(o_id_valid),  32'd0);
        check({tag, "_err"},   32'(o_align_err), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        ovr_addr = 32'h0000_0001;
        ovr_word = 32'd0;
        mem_lat  = 1;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: back-to-back fetch from RESET_PC
        tick();
        check("t1_addr0",  o_imem_addr, 32'h0040_0000);
        check("t1_valid0", 32'(o_id_valid), 32'd0);
        tick();
        check("t1_addr1",  o_imem_addr, 32'h0040_0004);
        check("t1_valid1", 32'(o_id_valid), 32'd1);
        check("t1_pc4",    o_id_pc4, 32'h0040_0004);
        tick();
        check("t1_addr2",  o_imem_addr, 32'h0040_0008);
        tick();

        // 2: three-cycle stall, word arrives in the first stalled cycle
        i_stall = 1'b1;
        tick();
        check("t2_req_low", 32'(o_imem_req), 32'd0);
        tick();
        tick();
        check("t2_held_pc4", o_id_pc4, 32'h0040_000C);
        i_stall = 1'b0;
        tick();
        check("t2_skid_pc4",   o_id_pc4, 32'h0040_0010);
        check("t2_skid_instr", o_id_instr, mem_word(32'h0040_000C));
        check("t2_next_addr",  o_imem_addr, 32'h0040_0010);

        // 3: taken branch with the fetch acked in the same cycle
        i_branch_taken = 1'b1; i_branch_target = 32'h0040_0040;
        tick();
        clear_redirect();
        check("t3_bubble_valid", 32'(o_id_valid), 32'd0);
        check("t3_bubble_instr", o_id_instr, 32'd0);
        check("t3_addr",         o_imem_addr, 32'h0040_0040);
        tick();
        check("t3_target_pc4",   o_id_pc4, 32'h0040_0044);

        // 4: j while a 3-cycle fetch is outstanding
        ovr_addr = 32'h0040_0080;
        ovr_word = {OP_J, 26'h010_0010};
        i_branch_taken = 1'b1; i_branch_target = 32'h0040_0080;
        tick();
        clear_redirect();
        tick();
        check("t4_opcode", 32'(o_instr_code), 32'(OP_J));
        mem_lat = 3;
        i_jump = 1'b1;
        tick();
        clear_redirect();
        check("t4_addr_held", o_imem_addr, 32'h0040_0084);
        check("t4_bubble",    32'(o_id_valid), 32'd0);
        tick();
        tick();
        check("t4_stale_dropped", 32'(o_id_valid), 32'd0);
        check("t4_addr_target",   o_imem_addr, 32'h0040_0040);
        mem_lat = 1;
        tick();
        check("t4_target_valid", 32'(o_id_valid), 32'd1);

        // 5: jr wins over j and branch, misaligned target
        i_jump = 1'b1; i_jmp_reg = 1'b1; i_branch_taken = 1'b1;
        i_branch_target = 32'h0040_0200; i_jr_addr = 32'h0040_0102;
        tick();
        clear_redirect();
        check("t5_addr", o_imem_addr, 32'h0040_0100);
        check("t5_err",  32'(o_align_err), 32'd1);
        repeat (3) tick();
        check("t5_err_sticky", 32'(o_align_err), 32'd1);

        // PC wrap at the top of the address space
        i_branch_taken = 1'b1; i_branch_target = 32'hFFFF_FFFC;
        tick();
        clear_redirect();
        check("wrap_addr_top", o_imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_zero", o_imem_addr, 32'd0);
        check("wrap_pc4_zero",  o_id_pc4, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 220; i++) begin
            mem_lat = int'($urandom_range(1, 3));
            i_stall = ($urandom_range(0, 4) == 0);
            i_branch_target = $urandom() & 32'hFFFF_FFFC;
            i_jr_addr = $urandom();
            r = $urandom_range(0, 9);
            clear_redirect();
            case (r)
                0: i_branch_taken = 1'b1;
                1: i_jump = 1'b1;
                2: begin i_jump = 1'b1; i_jmp_reg = 1'b1; end
                3: begin i_jump = 1'b1; i_jmp_reg = 1'b1; i_branch_taken = 1'b1; end
                default: ;
            endcase
            tick();
        end
        clear_redirect();
        i_stall = 1'b0;

        // 6: asynchronous reset while a request is outstanding
        mem_lat = 3;
        tick();
        check("t6_req_pending", 32'(o_imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        model_reset();
        i_imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_lat = 1;
        tick();
        check("t6_refetch_addr", o_imem_addr, RPC);
        check("t6_refetch_req",  32'(o_imem_req), 32'd1);
        tick();
        check("t6_refetch_pc4",  o_id_pc4, 32'h0040_0004);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
